// File: rtl/cpu_seq_if.sv
// Handshake and strobe bundle between the RISC-Bubble sequencer and the fetch unit, register file and ALU.
// The master side is the sequencer; the slave side is the datapath or a testbench.
interface cpu_seq_if #(
   parameter int PC_W = 16
);
   logic            run;
   logic            ins_req;
   logic            ins_ack;
   logic [31:0]     ins;
   logic [PC_W-1:0] pc;
   logic            rf_rd_en;
   logic            rf_wr_en;
   logic [4:0]      rf_wr_addr;
   logic            alu_start;
   logic [2:0]      alu_op;
   logic            alu_done;
   logic            alu_zero;
   logic            busy;
   logic            halted;
   logic            illegal;
   logic            fault;

   modport master (
      input  run, ins_ack, ins, alu_done, alu_zero,
      output ins_req, pc, rf_rd_en, rf_wr_en, rf_wr_addr, alu_start, alu_op,
             busy, halted, illegal, fault
   );

   modport slave (
      output run, ins_ack, ins, alu_done, alu_zero,
      input  ins_req, pc, rf_rd_en, rf_wr_en, rf_wr_addr, alu_start, alu_op,
             busy, halted, illegal, fault
   );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the RISC-Bubble datapath.
// Optional watchdog on FETCH/EXEC waits is enabled by defining SEQ_TIMEOUT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | stopped at an instruction boundary, waiting for run
// S_FETCH  | ins_req high, waiting for ins_ack
// S_DECODE | rf_rd_en pulse, opcode class already latched
// S_EXEC   | alu_start pulse on entry, waiting for alu_done
// S_WB     | rf_wr_en pulse, pc advances by 4 on exit
// S_BRANCH | resolve BEQ/BNE from latched zero flag, update pc on exit
// S_HALT   | absorbing; only rst_n leaves
module cpu_seq_ctrl #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 15
) (
   input logic       clk,
   input logic       rst_n,
   cpu_seq_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_BRANCH, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_BEQ, C_BNE, C_HALT, C_ILL
   } cls_t;

   state_t          state_q, state_d;
   cls_t            cls_q, cls_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     imm_q, imm_d;
   logic            zero_q, zero_d;
   logic [2:0]      alu_op_q, alu_op_d;
   logic [4:0]      wr_addr_q, wr_addr_d;
   logic            illegal_q, illegal_d;
   logic            ins_req_q, ins_req_d;
   logic            rd_en_q, rd_en_d;
   logic            wr_en_q, wr_en_d;
   logic            start_q, start_d;
   logic            busy_q, busy_d;
   logic            halted_q, halted_d;

   logic [31:0]     br_off;
   logic [PC_W-1:0] pc_inc;
   logic            taken;
   logic [4:0]      unused_ins;

   assign unused_ins = bus.ins[25:21];
   assign br_off     = {{14{imm_q[15]}}, imm_q, 2'b00};
   assign pc_inc     = pc_q + PC_W'(4);
   assign taken      = ((cls_q == C_BEQ) && zero_q) || ((cls_q == C_BNE) && !zero_q);

`ifdef SEQ_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          fault_q, fault_d;
`else
   logic [31:0]   unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
`endif

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      pc_d      = pc_q;
      imm_d     = imm_q;
      zero_d    = zero_q;
      alu_op_d  = alu_op_q;
      wr_addr_d = wr_addr_q;
      illegal_d = illegal_q;
`ifdef SEQ_TIMEOUT_EN
      fault_d   = fault_q;
`endif
      case (state_q)
         S_IDLE: if (bus.run) state_d = S_FETCH;
         S_FETCH: begin
            if (bus.ins_ack) begin
               state_d = S_DECODE;
               imm_d   = bus.ins[15:0];
               case (bus.ins[31:26])
                  6'd0, 6'd12: begin cls_d = C_ALU; alu_op_d = 3'd0; wr_addr_d = bus.ins[15:11]; end
                  6'd1, 6'd2:  begin cls_d = C_ALU; alu_op_d = 3'd1; wr_addr_d = bus.ins[20:16]; end
                  6'd10, 6'd15: begin cls_d = C_ALU; alu_op_d = 3'd2; wr_addr_d = bus.ins[15:11]; end
                  6'd4:  begin cls_d = C_BEQ; alu_op_d = 3'd7; end
                  6'd5:  begin cls_d = C_BNE; alu_op_d = 3'd7; end
                  6'd63: cls_d = C_HALT;
                  default: cls_d = C_ILL;
               endcase
            end
`ifdef SEQ_TIMEOUT_EN
            else if (tmr_q == '0) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end
`endif
         end
         S_DECODE: begin
            case (cls_q)
               C_HALT: state_d = S_HALT;
               C_ILL: begin
                  illegal_d = 1'b1;
                  pc_d      = pc_inc;
                  state_d   = bus.run ? S_FETCH : S_IDLE;
               end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            // start_q marks the first EXEC cycle, where alu_done is not yet trusted
            if (!start_q && bus.alu_done) begin
               zero_d  = bus.alu_zero;
               state_d = ((cls_q == C_BEQ) || (cls_q == C_BNE)) ? S_BRANCH : S_WB;
            end
`ifdef SEQ_TIMEOUT_EN
            else if (tmr_q == '0) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end
`endif
         end
         S_WB: begin
            pc_d    = pc_inc;
            state_d = bus.run ? S_FETCH : S_IDLE;
         end
         S_BRANCH: begin
            pc_d    = taken ? (pc_inc + br_off[PC_W-1:0]) : pc_inc;
            state_d = bus.run ? S_FETCH : S_IDLE;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      ins_req_d = (state_d == S_FETCH);
      rd_en_d   = (state_d == S_DECODE);
      start_d   = (state_d == S_EXEC) && (state_q != S_EXEC);
      wr_en_d   = (state_d == S_WB);
      busy_d    = (state_d != S_IDLE) && (state_d != S_HALT);
      halted_d  = (state_d == S_HALT);

`ifdef SEQ_TIMEOUT_EN
      if (state_d != state_q)
         tmr_d = TW'(TIMEOUT - 1);
      else if (tmr_q != '0)
         tmr_d = tmr_q - 1'b1;
      else
         tmr_d = tmr_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cls_q     <= C_ALU;
         pc_q      <= RESET_PC;
         imm_q     <= '0;
         zero_q    <= 1'b0;
         alu_op_q  <= '0;
         wr_addr_q <= '0;
         illegal_q <= 1'b0;
         ins_req_q <= 1'b0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         tmr_q     <= '0;
         fault_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         pc_q      <= pc_d;
         imm_q     <= imm_d;
         zero_q    <= zero_d;
         alu_op_q  <= alu_op_d;
         wr_addr_q <= wr_addr_d;
         illegal_q <= illegal_d;
         ins_req_q <= ins_req_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         halted_q  <= halted_d;
`ifdef SEQ_TIMEOUT_EN
         tmr_q     <= tmr_d;
         fault_q   <= fault_d;
`endif
      end
   end

   assign bus.ins_req    = ins_req_q;
   assign bus.pc         = pc_q;
   assign bus.rf_rd_en   = rd_en_q;
   assign bus.rf_wr_en   = wr_en_q;
   assign bus.rf_wr_addr = wr_addr_q;
   assign bus.alu_start  = start_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.busy       = busy_q;
   assign bus.halted     = halted_q;
   assign bus.illegal    = illegal_q;
`ifdef SEQ_TIMEOUT_EN
   assign bus.fault      = fault_q;
`else
   assign bus.fault      = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: directed scenarios plus randomized instruction streams
// checked against an instruction-level model of pc, write strobes and sticky flags.
module tb_cpu_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   int   pc_m = 0;
   bit   illegal_m = 1'b0;
   logic [5:0] legal [8] = '{6'd0, 6'd12, 6'd1, 6'd2, 6'd10, 6'd15, 6'd4, 6'd5};

   cpu_seq_if #(.PC_W(16)) bus ();

   cpu_seq_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] low);
      return {op, 5'd1, rt, low};
   endfunction

   // 0 = ALU, 1 = BEQ, 2 = BNE, 3 = HALT, 4 = illegal
   function automatic int cls_of(input logic [5:0] op);
      if (op == 0 || op == 12 || op == 1 || op == 2 || op == 10 || op == 15) return 0;
      if (op == 4) return 1;
      if (op == 5) return 2;
      if (op == 63) return 3;
      return 4;
   endfunction

   task automatic boundary(input bit dropped);
      chk("boundary_pc", bus.pc, pc_m);
      chk("boundary_wr", bus.rf_wr_en, 0);
      chk("boundary_illegal", bus.illegal, illegal_m);
      if (dropped) begin
         chk("idle_req", bus.ins_req, 0);
         chk("idle_busy", bus.busy, 0);
         bus.run = 1'b1;
         @(negedge clk);
      end
      chk("next_fetch", bus.ins_req, 1);
   endtask

   // Called at a negedge with the DUT in its first FETCH cycle; returns at the next FETCH.
   task automatic exec_instr(input logic [31:0] ins, input int ack_dly, input int done_dly,
                             input bit zero, input bit drop_run);
      logic [5:0] op;
      int cls, exp_op, exp_addr, tgt;
      op  = ins[31:26];
      cls = cls_of(op);
      exp_op   = (op == 0 || op == 12) ? 0 : (op == 1 || op == 2) ? 1 : (op == 10 || op == 15) ? 2 : 7;
      exp_addr = (op == 1 || op == 2) ? int'(ins[20:16]) : int'(ins[15:11]);
      chk("fetch_req", bus.ins_req, 1);
      chk("fetch_pc", bus.pc, pc_m);
      for (int i = 0; i < ack_dly; i++) begin
         bus.ins_ack = 1'b0;
         bus.ins = $urandom;
         @(negedge clk);
         chk("stall_req", bus.ins_req, 1);
      end
      bus.ins_ack = 1'b1;
      bus.ins = ins;
      if (drop_run && cls == 4) bus.run = 1'b0;
      @(negedge clk);
      bus.ins_ack = 1'b0;
      bus.ins = $urandom;
      chk("decode_rd", bus.rf_rd_en, 1);
      if (cls < 3) chk("decode_op", bus.alu_op, exp_op);
      if (cls == 3) begin
         @(negedge clk);
         chk("halted", bus.halted, 1);
         chk("halt_busy", bus.busy, 0);
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("halt_no_req", bus.ins_req, 0);
         end
         return;
      end
      if (cls == 4) begin
         @(negedge clk);
         pc_m = (pc_m + 4) & 32'hFFFF;
         illegal_m = 1'b1;
         boundary(drop_run);
         return;
      end
      @(negedge clk);
      chk("exec_start", bus.alu_start, 1);
      bus.alu_done = 1'($urandom_range(0, 1));
      bus.alu_zero = ~zero;
      @(negedge clk);
      chk("exec_start_pulse", bus.alu_start, 0);
      chk("exec_no_wr", bus.rf_wr_en, 0);
      for (int i = 0; i < done_dly; i++) begin
         bus.alu_done = 1'b0;
         bus.ins_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      bus.ins_ack = 1'b0;
      bus.alu_done = 1'b1;
      bus.alu_zero = zero;
      if (drop_run) bus.run = 1'b0;
      @(negedge clk);
      bus.alu_done = 1'b0;
      bus.alu_zero = 1'($urandom_range(0, 1));
      chk("wb_strobe", bus.rf_wr_en, (cls == 0) ? 1 : 0);
      if (cls == 0) chk("wb_addr", bus.rf_wr_addr, exp_addr);
      chk("wb_op_held", bus.alu_op, exp_op);
      chk("wb_pc_held", bus.pc, pc_m);
      tgt = pc_m + 4;
      if ((cls == 1 && zero) || (cls == 2 && !zero)) tgt = tgt + int'($signed(ins[15:0])) * 4;
      pc_m = tgt & 32'hFFFF;
      @(negedge clk);
      boundary(drop_run);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.run = 1'b0;
      bus.ins_ack = 1'b0;
      bus.ins = '0;
      bus.alu_done = 1'b0;
      bus.alu_zero = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pc", bus.pc, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_req", bus.ins_req, 0);
      chk("rst_illegal", bus.illegal, 0);
      chk("rst_fault", bus.fault, 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_op", bus.alu_op, 0);
      chk("rst_addr", bus.rf_wr_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_no_run", bus.ins_req, 0);
      bus.run = 1'b1;
      @(negedge clk);

      exec_instr(mk(6'd0, 5'd2, 16'h2800), 0, 0, 1'b0, 1'b0);
      chk("start_pc4", bus.pc, 32'h4);
      exec_instr(mk(6'd1, 5'd7, 16'h1234), 0, 0, 1'b0, 1'b0);
      exec_instr(mk(6'd12, 5'd3, 16'hF800), 1, 2, 1'b1, 1'b0);
      exec_instr(mk(6'd2, 5'd9, 16'h0001), 0, 1, 1'b0, 1'b0);
      exec_instr(mk(6'd4, 5'd2, 16'hFFFE), 0, 0, 1'b1, 1'b0);
      chk("beq_taken", bus.pc, 32'hC);
      exec_instr(mk(6'd10, 5'd4, 16'h0800), 0, 0, 1'b0, 1'b0);
      exec_instr(mk(6'd4, 5'd2, 16'hFFFE), 0, 0, 1'b0, 1'b0);
      chk("beq_not_taken", bus.pc, 32'h14);
      exec_instr(mk(6'd15, 5'd4, 16'hF800), 3, 1, 1'b0, 1'b1);

      bus.ins_ack = 1'b1;
      bus.ins = mk(6'd0, 5'd3, 16'h2800);
      @(negedge clk);
      bus.ins_ack = 1'b0;
      @(negedge clk);
      chk("pre_rst_start", bus.alu_start, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_start", bus.alu_start, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_pc", bus.pc, 0);
      chk("arst_op", bus.alu_op, 0);
      chk("arst_wr", bus.rf_wr_en, 0);
      pc_m = 0;
      illegal_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      exec_instr(mk(6'd5, 5'd2, 16'h0003), 0, 0, 1'b0, 1'b0);
      chk("bne_taken", bus.pc, 32'h10);
      exec_instr(mk(6'd4, 5'd2, 16'hFFFA), 0, 0, 1'b1, 1'b0);
      chk("to_fffc", bus.pc, 32'hFFFC);
      exec_instr(mk(6'd1, 5'd5, 16'h0000), 0, 0, 1'b0, 1'b0);
      chk("pc_wrap", bus.pc, 32'h0);
      chk("pre_illegal", bus.illegal, 0);
      exec_instr(mk(6'd7, 5'd0, 16'h0000), 0, 0, 1'b0, 1'b0);
      chk("illegal_set", bus.illegal, 1);

      for (int k = 0; k < 60; k++) begin
         logic [5:0] op;
         int r;
         r = $urandom_range(0, 9);
         op = (r < 8) ? legal[r] : 6'($urandom_range(0, 62));
         exec_instr({op, 26'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      end

      bus.ins_ack = 1'b1;
      bus.ins = mk(6'd0, 5'd3, 16'h2800);
      @(negedge clk);
      bus.ins_ack = 1'b0;
      @(negedge clk);
      chk("wd_start", bus.alu_start, 1);
`ifdef SEQ_TIMEOUT_EN
      repeat (13) @(negedge clk);
      chk("wd_c14_halted", bus.halted, 0);
      @(negedge clk);
      chk("wd_c15_fault", bus.fault, 0);
      @(negedge clk);
      chk("wd_fault", bus.fault, 1);
      chk("wd_halted", bus.halted, 1);
      rst_n = 1'b0;
      pc_m = 0;
      illegal_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
`else
      repeat (20) @(negedge clk);
      chk("nowd_fault", bus.fault, 0);
      chk("nowd_busy", bus.busy, 1);
      bus.alu_done = 1'b1;
      @(negedge clk);
      bus.alu_done = 1'b0;
      chk("nowd_wb", bus.rf_wr_en, 1);
      pc_m = (pc_m + 4) & 32'hFFFF;
      @(negedge clk);
      boundary(1'b0);
`endif

      exec_instr(mk(6'd63, 5'd0, 16'h0000), 0, 0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle sequencer for the RISC-Bubble datapath. It owns the program counter and steps each instruction through fetch, decode, execute and write-back by driving request/enable strobes to the instruction fetch unit, register file and ALU. It also resolves BEQ/BNE branches from the ALU zero flag. It sits above `cpu`, replacing its free-running per-clock behaviour with an explicit, handshaked control FSM.

## Interface
- `PC_W`, 16, program counter width (byte address)
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `TIMEOUT`, 15, watchdog limit in cycles (used only with `SEQ_TIMEOUT_EN`)

- `clk`  in  1  system clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  level; 1 = keep issuing instructions
- `ins_req`  out  1  fetch request for instruction at `pc`
- `ins_ack`  in  1  fetch complete; `ins` valid this cycle
- `ins`  in  32  fetched instruction
- `pc`  out  PC_W  current instruction address
- `rf_rd_en`  out  1  register-file read strobe (1 cycle)
- `rf_wr_en`  out  1  register-file write strobe (1 cycle)
- `rf_wr_addr`  out  5  destination register
- `alu_start`  out  1  ALU start pulse (1 cycle)
- `alu_op`  out  3  ALU operation class, held from DECODE through WB/BRANCH
- `alu_done`  in  1  ALU result and `alu_zero` valid
- `alu_zero`  in  1  ALU zero flag
- `busy`  out  1  high in any state other than IDLE and HALT
- `halted`  out  1  HALT state reached
- `illegal`  out  1  sticky; undefined opcode decoded
- `fault`  out  1  sticky; watchdog expired (0 without macro)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, BRANCH, HALT.
- **IDLE:** goes to FETCH when `run`=1.
- **FETCH:** `ins_req`=1. When `ins_ack`=1 (may arrive in the first FETCH cycle), latch `ins` and go to DECODE.
- **DECODE:** pulse `rf_rd_en` and classify `ins[31:26]`:
  - 0 or 12 = R-type: `alu_op`=0, `rf_wr_addr`=`ins[15:11]`.
  - 1–2 = immediate: `alu_op`=1, `rf_wr_addr`=`ins[20:16]`.
  - 10 or 15 = shift: `alu_op`=2, `rf_wr_addr`=`ins[15:11]`.
  - 4 = BEQ: `alu_op`=7.
  - 5 = BNE: `alu_op`=7.
  - 63 = HALT.
  - All other opcodes: set `illegal`, add 4 to `pc`, then go to FETCH if `run`=1, otherwise IDLE. No write occurs.
- **EXEC:** pulse `alu_start` in the first EXEC cycle. `alu_done` is honoured only from the second EXEC cycle onward. On `alu_done`, go to BRANCH for branches and to WB for everything else.
- **WB:** pulse `rf_wr_en`, set `pc` = `pc`+4, then go to FETCH if `run`=1, otherwise IDLE.
- **BRANCH:** the branch is taken if (BEQ and `alu_zero`) or (BNE and !`alu_zero`).
  - Taken: `pc` = `pc`+4+(sext(`ins[15:0]`)<<2).
  - Not taken: `pc` = `pc`+4.
  - Then go to FETCH if `run`=1, otherwise IDLE.
- **HALT:** absorbing; `halted`=1. Only `rst_n` exits it.
- PC arithmetic is modulo 2^PC_W. Wrap from 16'hFFFC+4 gives 16'h0000 and raises no flag.
- `run` deassertion mid-instruction: the current instruction completes and the FSM stops at the instruction boundary.

## Timing
- Reset (async assert, sync release): state=IDLE, `pc`=RESET_PC, `illegal`=0, `fault`=0. All other outputs reset to 0, including `alu_op`=0 and `rf_wr_addr`=0.
- Minimum latency with `ins_ack` and `alu_done` at the earliest allowed cycle:
  - ALU instruction: 5 cycles (FETCH, DECODE, EXEC×2, WB).
  - Branch: 5 cycles.
  - Illegal opcode: 2 cycles.
- `pc` updates on the clock edge leaving WB or BRANCH. The new value is visible in the next FETCH cycle.
- `ins_ack` outside FETCH and `alu_done` outside EXEC are ignored.
- `rst_n` asserted in any state aborts the instruction with no write strobe. Outputs clear asynchronously.

## Configuration
- `SEQ_TIMEOUT_EN` defined: a counter runs in FETCH and EXEC.
  - It clears on state entry.
  - If it reaches TIMEOUT without the awaited handshake, set `fault` and go to HALT. For example, with TIMEOUT=15, a wait of 15 cycles trips it.
- `SEQ_TIMEOUT_EN` undefined: no counter; waits are unbounded; `fault` is tied 0.

## Test plan
- **Reset and start:** reset, then `run`=1, `ins`=R-type, `ins_ack` in the first FETCH cycle, `alu_done` in the second EXEC cycle. Expect `rf_wr_en` in cycle 5 with `rf_wr_addr`=`ins[15:11]`, and `pc`=0x0004 afterwards.
- **BEQ taken:** BEQ at `pc`=0x0010 with imm=0xFFFE and `alu_zero`=1 → `pc`=0x000C. The same instruction with `alu_zero`=0 → `pc`=0x0014. `rf_wr_en` is never asserted.
- **BNE:** BNE with `alu_zero`=0 and imm=3 at `pc`=0 → `pc`=0x0010.
- **Illegal then halt:** opcode 7 → `illegal`=1, no write, `pc`+=4. Then opcode 63 → `halted`=1, `busy`=0, and no further `ins_req` while `run`=1.
- **Stalls and run drop:** delay `ins_ack` by 3 cycles and drop `run` during EXEC. Expect the instruction to complete with a WB strobe, then IDLE with `ins_req`=0.
- **Reset mid-EXEC and timeout:** assert `rst_n`=0 mid-EXEC → outputs clear immediately and `pc`=RESET_PC. With `SEQ_TIMEOUT_EN` defined, withhold `alu_done` for 15 cycles → `fault`=1 and `halted`=1.
